// File: rtl/falling_byte_column_pkg.sv
// Shared types and constants for the Flippy Bit playfield columns.
package flippy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FALLING = 2'd1,
        OVER    = 2'd2
    } col_state_e;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam int         ROWS_DEFAULT = 30;

    // Feedback bit for x^8+x^6+x^5+x^4+1 with the register shifting towards the MSB.
    function automatic logic lfsr_fb(input logic [7:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/falling_byte_column_if.sv
// Switch input and display/state-machine outputs of one playfield column.
interface falling_byte_column_if;
    logic [7:0] user_input;
    logic [4:0] ypos;
    logic [7:0] letter;
    logic       correct;
    logic       game_over;
    logic       active;

    modport master (
        output user_input,
        input  ypos, letter, correct, game_over, active
    );

    modport slave (
        input  user_input,
        output ypos, letter, correct, game_over, active
    );
endinterface

// File: rtl/falling_byte_column_lfsr8.sv
// 8-bit Fibonacci LFSR supplying the target bytes; holds while enable is low.
module lfsr8
    import flippy_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic       enable,
    output logic [7:0] value
);

    logic [7:0] value_q;

    // Shift register; a non-zero seed keeps the sequence away from the all-zero lockup.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            value_q <= SEED;
        end else if (enable) begin
            value_q <= {value_q[6:0], lfsr_fb(value_q)};
        end
    end

    assign value = value_q;

endmodule

// File: rtl/falling_byte_column.sv
// One playfield column: a target byte falls one row per tick and scores when
// the synchronised switches match it after having differed from it.
module falling_byte_column
    import flippy_pkg::*;
#(
    parameter int         ROWS        = ROWS_DEFAULT,
    parameter int         FALL_DIV    = 25000000,
    parameter int         SPAWN_DELAY = 2,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset_signal,
    falling_byte_column_if.slave  col
);

    localparam int             CW        = $clog2(FALL_DIV);
    localparam int             IW        = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
    localparam logic [CW-1:0]  TICK_MAX  = CW'(FALL_DIV - 1);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(SPAWN_DELAY - 1);
    localparam logic [4:0]     YPOS_LAST = 5'(ROWS - 1);

    col_state_e    state_q;
    logic [7:0]    sync1_q;
    logic [7:0]    sw_q;
    logic [CW-1:0] tick_cnt_q;
    logic [IW-1:0] idle_cnt_q;
    logic [4:0]    ypos_q;
    logic [7:0]    letter_q;
    logic          armed_q;
    logic          correct_q;
    logic          game_over_q;
    logic          active_q;

    logic [7:0]    lfsr_s;
    logic          lfsr_en_s;
    logic          tick_s;
    logic          match_s;
    logic          bottom_s;

    // Two-flop synchroniser for the asynchronous switch byte.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            sync1_q <= 8'h00;
            sw_q    <= 8'h00;
        end else begin
            sync1_q <= col.user_input;
            sw_q    <= sync1_q;
        end
    end

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clock        (clock),
        .reset_signal (reset_signal),
        .enable       (lfsr_en_s),
        .value        (lfsr_s)
    );

    // Decode of tick, match and bottom-row conditions from registered state.
    always_comb begin
        lfsr_en_s = (state_q != OVER);
        tick_s    = (tick_cnt_q == TICK_MAX);
        bottom_s  = (ypos_q == YPOS_LAST);
        match_s   = (state_q == FALLING) && armed_q && (sw_q == letter_q);
    end

    // Column FSM with registered outputs; a match outranks a bottom-row tick.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            ypos_q      <= 5'd0;
            letter_q    <= 8'h00;
            armed_q     <= 1'b0;
            correct_q   <= 1'b0;
            game_over_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            correct_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tick_cnt_q <= tick_s ? '0 : tick_cnt_q + CW'(1);
                    if (tick_s) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_q    <= FALLING;
                            idle_cnt_q <= '0;
                            tick_cnt_q <= '0;
                            letter_q   <= lfsr_s;
                            ypos_q     <= 5'd0;
                            armed_q    <= (sw_q != lfsr_s);
                            active_q   <= 1'b1;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IW'(1);
                        end
                    end
                end
                FALLING: begin
                    tick_cnt_q <= tick_s ? '0 : tick_cnt_q + CW'(1);
                    if (match_s) begin
                        correct_q  <= 1'b1;
                        letter_q   <= lfsr_s;
                        ypos_q     <= 5'd0;
                        armed_q    <= (sw_q != lfsr_s);
                        tick_cnt_q <= '0;
                    end else begin
                        if (sw_q != letter_q) begin
                            armed_q <= 1'b1;
                        end
                        if (tick_s) begin
                            if (bottom_s) begin
                                state_q     <= OVER;
                                game_over_q <= 1'b1;
                                active_q    <= 1'b0;
                            end else begin
                                ypos_q <= ypos_q + 5'd1;
                            end
                        end
                    end
                end
                OVER: begin
                    game_over_q <= 1'b1;
                    active_q    <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    tick_cnt_q  <= '0;
                    idle_cnt_q  <= '0;
                    active_q    <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign col.ypos      = ypos_q;
    assign col.letter    = letter_q;
    assign col.correct   = correct_q;
    assign col.game_over = game_over_q;
    assign col.active    = active_q;

endmodule
